// File: rtl/stack_pkg.sv
// Stack controller shared types: FSM state encoding and sticky error bit positions.
package stack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_e;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_UNF  = 1;
  localparam int unsigned ERR_DROP = 2;

endpackage

// File: rtl/stack_ctrl.sv
// Operand stack sequencer: owns the stack pointer, drives the single-port sync-read
// stack RAM and returns popped / top-of-stack data with a one-cycle valid pulse.
// Optional build macro STACK_TOS_CACHE_EN keeps a register mirroring mem[sp-1], so
// tos needs no RAM access and pop answers one cycle earlier (RD then refills the cache).
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_err,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic [AW:0]      sp,
  output logic             empty,
  output logic             full,
  output logic [2:0]       err
);

  state_e           state_q, state_d;
  logic [AW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       err_q, err_d;
`ifdef STACK_TOS_CACHE_EN
  logic [WIDTH-1:0] top_q, top_d;
`endif

  logic any_cmd;
  logic multi_cmd;
  logic is_empty;
  logic is_full;

  assign any_cmd   = push | pop | tos;
  assign multi_cmd = (push & pop) | (push & tos) | (pop & tos);
  assign is_empty  = (sp_q == '0);
  assign is_full   = (sp_q == (AW+1)'(DEPTH));

  // Next-state, RAM port and error logic; reset masks the RAM port combinationally.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = clr_err ? '0 : err_q;
    ram_we      = 1'b0;
    ram_addr    = sp_q[AW-1:0];
    ram_wdata   = push_data;
`ifdef STACK_TOS_CACHE_EN
    top_d       = top_q;
`endif

    if (!rst) begin
      if (state_q == RD) begin
        state_d = IDLE;
        if (any_cmd) err_d[ERR_DROP] = 1'b1;
`ifdef STACK_TOS_CACHE_EN
        top_d       = ram_rdata;
`else
        out_data_d  = ram_rdata;
        out_valid_d = 1'b1;
`endif
      end else if (any_cmd) begin
        if (multi_cmd) begin
          err_d[ERR_DROP] = 1'b1;
        end else if (push) begin
          if (is_full) begin
            err_d[ERR_OVF] = 1'b1;
          end else begin
            ram_we = 1'b1;
            sp_d   = sp_q + (AW+1)'(1);
`ifdef STACK_TOS_CACHE_EN
            top_d  = push_data;
`endif
          end
        end else if (is_empty) begin
          err_d[ERR_UNF] = 1'b1;
        end else begin
`ifdef STACK_TOS_CACHE_EN
          // Cached: answer straight from top; a pop refills top from mem[sp-2].
          out_data_d  = top_q;
          out_valid_d = 1'b1;
          if (pop) begin
            sp_d = sp_q - (AW+1)'(1);
            if (sp_q == (AW+1)'(1)) begin
              top_d = '0;
            end else begin
              ram_addr = sp_q[AW-1:0] - AW'(2);
              state_d  = RD;
            end
          end
`else
          ram_addr = sp_q[AW-1:0] - AW'(1);
          state_d  = RD;
          if (pop) sp_d = sp_q - (AW+1)'(1);
`endif
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
`ifdef STACK_TOS_CACHE_EN
      top_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
`ifdef STACK_TOS_CACHE_EN
      top_q       <= top_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == RD);
  assign sp        = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign err       = err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboarded random/directed bench for stack_ctrl against a queue-based stack model.
module tb_stack_ctrl;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int AW = 5;
`ifdef STACK_TOS_CACHE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst, push, pop, tos, clr_err;
  logic [W-1:0]  push_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_wdata, ram_rdata;
  logic [W-1:0]  out_data;
  logic          out_valid, busy, empty, full;
  logic [AW:0]   sp;
  logic [2:0]    err;

  stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos),
    .push_data(push_data), .clr_err(clr_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .sp(sp),
    .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sync-read single-port stack RAM.
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t       expq[$];
  logic [W-1:0] stk[$];
  logic [2:0] merr = '0;
  int         busy_cyc = -10;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got data 0x%0h expected no pulse at cycle %0d", out_data, cyc);
      end else begin
        e = expq.pop_front();
        if (out_data !== e.data) begin
          errors++;
          $display("FAIL out_data: got 0x%0h expected 0x%0h at cycle %0d", out_data, e.data, cyc);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL out_valid_cycle: got %0d expected %0d", cyc, e.due);
        end
      end
    end
  end

  // One command cycle: check state, drive inputs, check RAM port, advance model.
  task automatic step(input logic p, input logic o, input logic t, input logic c,
                      input logic [W-1:0] d);
    int   n        = cyc;
    int   sz       = stk.size();
    bit   bsy      = (busy_cyc == n);
    int   ncmd     = int'(p) + int'(o) + int'(t);
    logic [2:0] enew = '0;
    bit   exp_we   = 1'b0;
    bit   chk_addr = 1'b0;
    int   exp_addr = 0;
    exp_t e;
    chk("sp", int'(sp), sz);
    chk("empty", int'(empty), int'(sz == 0));
    chk("full", int'(full), int'(sz == D));
    chk("err", int'(err), int'(merr));
    chk("busy", int'(busy), int'(bsy));
    push = p; pop = o; tos = t; clr_err = c; push_data = d;
    #1;
    if (ncmd > 0) begin
      if (bsy || ncmd > 1) begin
        enew[2] = 1'b1;
      end else if (p) begin
        if (sz == D) enew[0] = 1'b1;
        else begin
          exp_we = 1'b1; chk_addr = 1'b1; exp_addr = sz;
          stk.push_back(d);
        end
      end else if (sz == 0) begin
        enew[1] = 1'b1;
      end else begin
        e.data = stk[sz-1];
        e.due  = n + LAT;
        expq.push_back(e);
`ifdef STACK_TOS_CACHE_EN
        if (o) begin
          void'(stk.pop_back());
          if (sz - 1 > 0) begin
            busy_cyc = n + 1; chk_addr = 1'b1; exp_addr = sz - 2;
          end
        end
`else
        busy_cyc = n + 1; chk_addr = 1'b1; exp_addr = sz - 1;
        if (o) void'(stk.pop_back());
`endif
      end
    end
    merr = (c ? 3'b000 : merr) | enew;
    chk("ram_we", int'(ram_we), int'(exp_we));
    if (chk_addr) chk("ram_addr", int'(ram_addr), exp_addr);
    if (exp_we) chk("ram_wdata", int'(ram_wdata), int'(d));
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0; push_data = '0;
    expq = expq.find(x) with (x.due <= cyc);
    busy_cyc = -10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    merr = '0;
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_valid", int'(out_valid), 0);
  endtask

  task automatic check_ram();
    for (int i = 0; i < stk.size(); i++) chk("ram_content", int'(mem[i]), int'(stk[i]));
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0; push_data = '0;
    do_reset();

    // Three pushes, then one pop.
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h22);
    step(1, 0, 0, 0, 8'h33);
    idle();
    check_ram();
    step(0, 1, 0, 0, '0);
    idle(); idle(); idle();

    // Fill past capacity.
    do_reset();
    for (int i = 0; i <= D; i++) step(1, 0, 0, 0, W'(i + 8'h40));
    idle();
    check_ram();

    // Underflow, then clear.
    do_reset();
    step(0, 1, 0, 0, '0);
    idle(); idle();
    step(0, 0, 0, 1, '0);
    idle();

    // Illegal combinations and commands while busy.
    step(1, 0, 0, 0, 8'h5);
    step(1, 0, 0, 0, 8'h6);
    step(1, 1, 0, 0, 8'h77);
    idle();
    step(0, 0, 0, 1, '0);
    step(0, 1, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    idle(); idle();
    step(1, 0, 1, 1, 8'h99);
    idle();

    // Cache-style sequence: tos, pop, tos.
    do_reset();
    step(1, 0, 0, 0, 8'h05);
    step(1, 0, 0, 0, 8'h06);
    step(0, 0, 1, 0, '0);
    idle(); idle();
    step(0, 1, 0, 0, '0);
    idle(); idle();
    step(0, 0, 1, 0, '0);
    idle(); idle();

    // Reset while a read is outstanding.
    step(0, 1, 0, 0, '0);
    do_reset();
    idle(); idle(); idle();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [W-1:0] d;
      r = int'($urandom_range(0, 199));
      d = W'($urandom);
      if      (r < 80)  step(1, 0, 0, 0, d);
      else if (r < 130) step(0, 1, 0, 0, d);
      else if (r < 160) step(0, 0, 1, 0, d);
      else if (r < 175) idle();
      else if (r < 184) step(1'($urandom), 1'($urandom), 1'($urandom), 0, d);
      else if (r < 198) step(1'($urandom), 1'($urandom), 0, 1, d);
      else do_reset();
    end

    for (int k = 0; k < 5; k++) idle();
    check_ram();
    chk("pending_responses", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
